// File: rtl/count_pkg.sv
// ---------------------------------------------------------------------------
// count_pkg
// Definitions shared by the count sequence checker and its Gray decoder:
// the count width, the two mode encodings on the mode wire, and the
// checker state type.
// ---------------------------------------------------------------------------
package count_pkg;

    localparam int unsigned CNT_W = 3;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

endpackage : count_pkg

// File: rtl/gray2bin_3.sv
// ---------------------------------------------------------------------------
// gray2bin_3
// Purely combinational 3-bit reflected-Gray to binary converter.
// Each binary bit is the XOR of the Gray bit at that position and every
// Gray bit above it.
//
// Ports:
//   gray_i  in  CNT_W  Gray-coded value
//   bin_o   out CNT_W  binary equivalent
// ---------------------------------------------------------------------------
module gray2bin_3
    import count_pkg::*;
(
    input  logic [CNT_W-1:0] gray_i,
    output logic [CNT_W-1:0] bin_o
);

    assign bin_o[2] = gray_i[2];
    assign bin_o[1] = gray_i[2] ^ gray_i[1];
    assign bin_o[0] = gray_i[2] ^ gray_i[1] ^ gray_i[0];

endmodule : gray2bin_3

// File: rtl/count_seq_checker.sv
// ---------------------------------------------------------------------------
// count_seq_checker
// Receive-side checker for a 3-bit counter that runs in binary (mode 0) or
// reflected Gray (mode 1). Every qualified sample is decoded to a binary
// index and compared with the previous index plus one (mod 8). After
// LOCK_N consecutive correct increments the checker locks; while locked, a
// wrong step raises seq_err and bumps a saturating error counter, and a
// 7->0 step raises wrap.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   valid      in   sample qualifier for count/mode
//   mode       in   encoding of count: 0 binary, 1 Gray
//   count      in   counter value (CNT_W bits)
//   err_clr    in   synchronous clear of err_cnt (independent of valid)
//   bin_out    out  registered decoded index, holds while valid=0
//   out_valid  out  registered copy of valid
//   locked     out  high while the state is LOCKED
//   seq_err    out  one-cycle pulse on a violation while LOCKED
//   wrap       out  one-cycle pulse on a 7->0 step while LOCKED
//   err_cnt    out  saturating count of seq_err events (ERR_W bits)
// ---------------------------------------------------------------------------
module count_seq_checker
    import count_pkg::*;
#(
    parameter int unsigned LOCK_N = 2,   // legal range 1..7
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             mode,
    input  logic [CNT_W-1:0] count,
    input  logic             err_clr,
    output logic [CNT_W-1:0] bin_out,
    output logic             out_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] LOCK_N_V = CNT_W'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] gray_bin;
    logic [CNT_W-1:0] idx;

    gray2bin_3 u_gray2bin (
        .gray_i (count),
        .bin_o  (gray_bin)
    );

    assign idx = (mode == MODE_GRAY) ? gray_bin : count;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] last_q,    last_d;
    logic [CNT_W-1:0] run_q,     run_d;
    logic             mode_q,    mode_d;
    logic [CNT_W-1:0] bin_q,     bin_d;
    logic             ovalid_q,  ovalid_d;
    logic             locked_q,  locked_d;
    logic             seq_err_q, seq_err_d;
    logic             wrap_q,    wrap_d;
    logic [ERR_W-1:0] err_q,     err_d;

    logic [CNT_W-1:0] exp_idx;
    logic             idx_ok;

    assign exp_idx = last_q + CNT_W'(1);
    assign idx_ok  = (idx == exp_idx);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        run_d     = run_q;
        mode_d    = mode_q;
        bin_d     = bin_q;
        ovalid_d  = valid;
        seq_err_d = 1'b0;
        wrap_d    = 1'b0;

        if (valid) begin
            bin_d  = idx;
            last_d = idx;
            if (mode != mode_q) begin
                // An encoding switch invalidates the history: restart
                // acquisition on the new encoding without flagging anything.
                mode_d  = mode;
                run_d   = '0;
                state_d = ST_ACQUIRE;
            end else begin
                unique case (state_q)
                    ST_UNLOCKED: begin
                        run_d   = '0;
                        state_d = ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (idx_ok) begin
                            run_d = run_q + CNT_W'(1);
                            if (run_q + CNT_W'(1) == LOCK_N_V) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (idx_ok) begin
                            wrap_d = (last_q == {CNT_W{1'b1}});
                        end else begin
                            seq_err_d = 1'b1;
                            run_d     = '0;
                            state_d   = ST_ACQUIRE;
                        end
                    end
                    default: begin
                        run_d   = '0;
                        state_d = ST_UNLOCKED;
                    end
                endcase
            end
        end

        // locked is a registered view of the next state.
        locked_d = (state_d == ST_LOCKED);

        // Clear wins over the increment, except that an error on the same
        // edge is still counted once.
        if (err_clr) begin
            err_d = seq_err_d ? ERR_ONE : '0;
        end else if (seq_err_d && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_ONE;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_UNLOCKED;
            last_q    <= '0;
            run_q     <= '0;
            mode_q    <= MODE_BIN;
            bin_q     <= '0;
            ovalid_q  <= 1'b0;
            locked_q  <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            run_q     <= run_d;
            mode_q    <= mode_d;
            bin_q     <= bin_d;
            ovalid_q  <= ovalid_d;
            locked_q  <= locked_d;
            seq_err_q <= seq_err_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = ovalid_q;
    assign locked    = locked_q;
    assign seq_err   = seq_err_q;
    assign wrap      = wrap_q;
    assign err_cnt   = err_q;

endmodule : count_seq_checker

// File: tb/tb_count_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_count_seq_checker
// Directed bench for count_seq_checker. Two instances share all inputs:
// dut8 uses the default ERR_W=8, dut2 uses ERR_W=2 to reach saturation.
// ---------------------------------------------------------------------------
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] count = 3'd0;
    logic       err_clr = 1'b0;

    logic [2:0] bin8, bin2;
    logic       ov8, ov2, lk8, lk2, se8, se2, wr8, wr2;
    logic [7:0] ec8;
    logic [1:0] ec2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    count_seq_checker #(.LOCK_N(2), .ERR_W(8)) dut8 (
        .clk(clk), .reset(reset), .valid(valid), .mode(mode), .count(count),
        .err_clr(err_clr), .bin_out(bin8), .out_valid(ov8), .locked(lk8),
        .seq_err(se8), .wrap(wr8), .err_cnt(ec8)
    );

    count_seq_checker #(.LOCK_N(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid(valid), .mode(mode), .count(count),
        .err_clr(err_clr), .bin_out(bin2), .out_valid(ov2), .locked(lk2),
        .seq_err(se2), .wrap(wr2), .err_cnt(ec2)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one input set, let one rising edge take it, return at edge+1.
    task automatic step(input logic v, input logic m, input logic [2:0] c,
                        input logic clr);
        valid   = v;
        mode    = m;
        count   = c;
        err_clr = clr;
        @(posedge clk);
        #1;
        $display("txn v=%0b m=%0b c=%0d clr=%0b -> bin=%0d ov=%0b lk=%0b se=%0b wr=%0b ec8=%0d ec2=%0d",
                 v, m, c, clr, bin8, ov8, lk8, se8, wr8, ec8, ec2);
    endtask

    // Repeat the last index (a violation while LOCKED).
    task automatic do_viol(input logic [2:0] c, input logic clr,
                           input int e8, input int e2);
        step(1'b1, 1'b0, c, clr);
        check_val("viol_seq_err", int'(se8), 1);
        check_val("viol_locked", int'(lk8), 0);
        check_val("viol_err8", int'(ec8), e8);
        check_val("viol_err2", int'(ec2), e2);
    endtask

    // Two correct increments from c bring the checker back to LOCKED.
    task automatic do_relock(input logic [2:0] c);
        step(1'b1, 1'b0, c + 3'd1, 1'b0);
        check_val("relock_mid", int'(lk8), 0);
        step(1'b1, 1'b0, c + 3'd2, 1'b0);
        check_val("relock_lk8", int'(lk8), 1);
        check_val("relock_lk2", int'(lk2), 1);
    endtask

    logic [2:0] lastv;
    logic [2:0] gseq [9];

    initial begin
        gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011;
        gseq[3] = 3'b010; gseq[4] = 3'b110; gseq[5] = 3'b111;
        gseq[6] = 3'b101; gseq[7] = 3'b100; gseq[8] = 3'b000;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_bin", int'(bin8), 0);
        check_val("rst_ov", int'(ov8), 0);
        check_val("rst_lk", int'(lk8), 0);
        check_val("rst_err", int'(ec8), 0);
        reset = 1'b1;

        // Binary 0..7,0,1
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 3'(i % 8), 1'b0);
            check_val("bin_out", int'(bin8), i % 8);
            check_val("bin_ov", int'(ov8), 1);
            check_val("bin_locked", int'(lk8), (i >= 2) ? 1 : 0);
            check_val("bin_wrap", int'(wr8), (i == 8) ? 1 : 0);
            check_val("bin_seq_err", int'(se8), 0);
        end

        // valid=0 gap: hold everything, pulses low
        step(1'b0, 1'b0, 3'd5, 1'b0);
        check_val("gap_ov", int'(ov8), 0);
        check_val("gap_bin_hold", int'(bin8), 1);
        check_val("gap_locked", int'(lk8), 1);

        // Violation 2,3,4,6 then 7,0,1 relock
        step(1'b1, 1'b0, 3'd2, 1'b0);
        step(1'b1, 1'b0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 3'd4, 1'b0);
        check_val("pre_viol_lk", int'(lk8), 1);
        step(1'b1, 1'b0, 3'd6, 1'b0);
        check_val("jump_seq_err", int'(se8), 1);
        check_val("jump_err8", int'(ec8), 1);
        check_val("jump_locked", int'(lk8), 0);
        step(1'b1, 1'b0, 3'd7, 1'b0);
        check_val("acq7_lk", int'(lk8), 0);
        check_val("acq7_se", int'(se8), 0);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        check_val("acq0_lk", int'(lk8), 1);
        check_val("acq0_wrap", int'(wr8), 0);
        step(1'b1, 1'b0, 3'd1, 1'b0);
        check_val("acq1_lk", int'(lk8), 1);

        // Mode switch to Gray 011 (idx 2), then 010, 110
        step(1'b1, 1'b1, 3'b011, 1'b0);
        check_val("msw_se", int'(se8), 0);
        check_val("msw_lk", int'(lk8), 0);
        check_val("msw_bin", int'(bin8), 2);
        step(1'b1, 1'b1, 3'b010, 1'b0);
        check_val("g010_bin", int'(bin8), 3);
        check_val("g010_lk", int'(lk8), 0);
        step(1'b1, 1'b1, 3'b110, 1'b0);
        check_val("g110_bin", int'(bin8), 4);
        check_val("g110_lk", int'(lk8), 1);

        // Back to binary at 0: mode change beats the (would-be) violation
        step(1'b1, 1'b0, 3'd0, 1'b0);
        check_val("msw2_se", int'(se8), 0);
        check_val("msw2_err", int'(ec8), 1);
        check_val("msw2_lk", int'(lk8), 0);
        step(1'b1, 1'b0, 3'd1, 1'b0);
        step(1'b1, 1'b0, 3'd2, 1'b0);
        check_val("msw2_relock", int'(lk8), 1);
        lastv = 3'd2;

        // Four more violations: dut8 counts 2..5, dut2 saturates at 3
        for (int k = 0; k < 4; k++) begin
            do_viol(lastv, 1'b0, 2 + k, (2 + k > 3) ? 3 : 2 + k);
            do_relock(lastv);
            lastv = lastv + 3'd2;
        end

        // Clear together with a violation -> 1; clear alone -> 0
        do_viol(lastv, 1'b1, 1, 1);
        do_relock(lastv);
        lastv = lastv + 3'd2;
        step(1'b0, 1'b0, 3'd0, 1'b1);
        check_val("clr_err8", int'(ec8), 0);
        check_val("clr_err2", int'(ec2), 0);
        check_val("clr_lk", int'(lk8), 1);

        // Build err_cnt=3 while ending LOCKED
        for (int k = 0; k < 3; k++) begin
            do_viol(lastv, 1'b0, 1 + k, 1 + k);
            do_relock(lastv);
            lastv = lastv + 3'd2;
        end
        valid = 1'b0;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #1 reset = 1'b0;
        #1;
        check_val("arst_lk", int'(lk8), 0);
        check_val("arst_err8", int'(ec8), 0);
        check_val("arst_err2", int'(ec2), 0);
        check_val("arst_bin", int'(bin8), 0);
        check_val("arst_ov", int'(ov8), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Gray full sequence from reset
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, gseq[i], 1'b0);
            check_val("gray_bin", int'(bin8), i % 8);
            check_val("gray_locked", int'(lk8), (i >= 2) ? 1 : 0);
            check_val("gray_wrap", int'(wr8), (i == 8) ? 1 : 0);
            check_val("gray_seq_err", int'(se8), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_count_seq_checker

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side checker for the 3-bit mode-selectable counter (mode 0 = binary, mode 1 = reflected Gray).
- Samples the count and mode pair, decodes it to a binary index, and tracks the expected increment sequence.
- Flags sequence errors and wrap events, and keeps a saturating error count.
- Sits downstream of the counter in the bench and system datapath, as the consumer end of its count interface.

Parameters:
- LOCK_N, 2, consecutive correct increments needed in ACQUIRE before entering LOCKED; legal range 1..7.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  count/mode sample qualifier.
- mode  in  1  encoding of count: 0 binary, 1 Gray.
- count  in  3  counter value.
- err_clr  in  1  synchronous clear of err_cnt.
- bin_out  out  3  registered decoded binary index.
- out_valid  out  1  registered copy of valid.
- locked  out  1  level, high while state is LOCKED.
- seq_err  out  1  one-cycle pulse on a sequence violation while LOCKED.
- wrap  out  1  one-cycle pulse on a 7->0 step while LOCKED.
- err_cnt  out  ERR_W  saturating count of seq_err events.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state UNLOCKED, last=0, run=0, mode_q=0.
- Latency: inputs are sampled on the rising edge where valid=1; all outputs update on that same edge, so they are visible one cycle after the inputs were presented.
- Decode:
  - mode 0: idx = count.
  - mode 1: idx[2] = g2; idx[1] = g2^g1; idx[0] = g2^g1^g0.
  - Gray sequence is 000,001,011,010,110,111,101,100.
- Expected next index: (last+1) mod 8, 3-bit wrap.
- valid=0 edge: no state, last, run or mode_q change; out_valid, seq_err and wrap are 0; bin_out holds its value.
- State UNLOCKED: on a sample, last=idx, run=0, go to ACQUIRE. No error or wrap.
- State ACQUIRE: on a sample:
  - If idx is the expected next, run=run+1; go to LOCKED when run+1==LOCK_N.
  - Otherwise run=0 and stay in ACQUIRE.
  - last=idx in both cases. Never asserts seq_err.
- State LOCKED: on a sample:
  - If idx is the expected next: stay LOCKED; assert wrap if last==7.
  - Otherwise: assert seq_err, increment err_cnt, set run=0, go to ACQUIRE.
  - last=idx in both cases.
  - A repeated value (idx==last) is a violation.
- Mode change: if the sampled mode differs from mode_q, then last=idx, run=0, state goes to ACQUIRE (from any state), mode_q=mode. No seq_err or wrap. This check takes priority over all state rules.
- err_cnt:
  - Saturates at all-ones; a further error leaves it unchanged.
  - err_clr alone sets it to 0.
  - err_clr together with a seq_err sets it to 1.
  - err_clr acts regardless of valid.
- locked is registered and reflects the next state, so it rises on the edge of the LOCK_N-th correct increment.
- Reset mid-operation: immediate return to the reset values; the first valid sample afterwards is treated as in UNLOCKED.

Decomposition:
- Shared package count_pkg:
  - CNT_W=3.
  - MODE_BIN=1'b0, MODE_GRAY=1'b1.
  - State enum {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED}.
- Sub-module gray2bin_3: purely combinational 3-bit Gray-to-binary converter, instantiated once. The mode mux selects between its output and the raw count.

Test Plan:
- Reset asserted mid-stream while LOCKED with err_cnt=3 -> all outputs 0 immediately, without waiting for clk; after release, the first sample gives state ACQUIRE and locked=0.
- mode=0, valid=1 every cycle, count 0,1,2,...,7,0,1 -> locked rises one cycle after the 3rd sample; wrap pulses exactly once, on the 7->0 sample; seq_err is never asserted; bin_out follows count with 1-cycle delay.
- mode=1, count sequence 000,001,011,010,110,111,101,100,000 -> bin_out 0..7,0; locked after 3 samples; a single wrap pulse; no seq_err.
- LOCKED in binary, inject count 3,4,6 -> seq_err pulse on the 6 sample; err_cnt=1; locked drops; then 7,0,1 -> relocks (locked=1 on the sample of 0) with wrap=0 (7->0 was seen in ACQUIRE).
- LOCKED binary, then switch mode to 1 mid-stream with Gray 011 -> no seq_err, state ACQUIRE, bin_out=2; Gray 010,110 continues -> locked=1 after 110.
- ERR_W=2: force 5 violations, each followed by a relock -> err_cnt saturates at 3; then err_clr together with a violation -> err_cnt=1; err_clr alone -> 0.
